sram_seq_ctrl: RTL and testbench

Two-requester transaction sequencer for the mixed-signal SRAM macro (`sram_top`).
- Accepts parallel write/read requests from two clients and arbitrates between them round-robin.
- Converts each write into the macro's serial shift, load and write-enable sequence; issues reads and captures `data_out` on `data_valid`.
- Returns one response per accepted request.
- Sits between the system-side clients and the `sram_top` control/serial pins.

---
 rtl/sram_seq_pkg.sv | 31 +++
 rtl/sram_seq_rr_arb.sv | 42 ++++
 rtl/sram_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sram_seq_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_pkg.sv
// sram_seq_pkg
//   Shared definitions for the sram_seq_ctrl slice: default geometry of the
//   SRAM macro, the sequencer FSM state encoding and a request record.
//   The request record is sized for the default geometry and is meant for
//   code that works at that geometry (models, stimulus generators).
//   Optional feature macro used by the slice: SRAM_SEQ_TIMEOUT_EN.
package sram_seq_pkg;

  localparam int DEF_ROWS    = 16;
  localparam int DEF_COLS    = 8;
  localparam int DEF_TIMEOUT = 15;
  localparam int DEF_AW      = $clog2(DEF_ROWS);

  // Explicit encodings keep the state values stable for older tools and
  // for anyone decoding state from a waveform by number.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4,
    ST_RESP  = 3'd5
  } sram_seq_state_e;

  typedef struct packed {
    logic                we;
    logic [DEF_AW-1:0]   addr;
    logic [DEF_COLS-1:0] wdata;
  } sram_seq_req_t;

endpackage

// File: rtl/sram_seq_rr_arb.sv
// sram_seq_rr_arb
//   Two-way round-robin arbiter for the SRAM sequencer.
//   The requester under the pointer wins if it is valid, otherwise the other
//   one does. The pointer moves to the loser only when a grant is actually
//   taken, i.e. while en_i is high and some request is valid.
// Ports:
//   clk        in   clock, rising edge
//   arst_n     in   synchronous active-low reset (pointer -> 0)
//   valid_i    in   [1:0] request valid per requester
//   en_i       in   sequencer is able to accept (IDLE)
//   gnt_idx_o  out  index of the granted requester
//   gnt_vld_o  out  some requester is valid, gnt_idx_o is meaningful
module sram_seq_rr_arb
  import sram_seq_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  output logic       gnt_idx_o,
  output logic       gnt_vld_o
);

  logic ptr_q;
  logic ptr_d;

  assign gnt_idx_o = valid_i[ptr_q] ? ptr_q : ~ptr_q;
  assign gnt_vld_o = |valid_i;

  // After a grant the other requester gets priority, so a continuously
  // requesting pair alternates.
  assign ptr_d = (en_i && gnt_vld_o) ? ~gnt_idx_o : ptr_q;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_seq_ctrl.sv
// sram_seq_ctrl
//   Two-requester transaction sequencer for the sram_top macro. Accepts one
//   write or read at a time (round-robin between requesters), turns a write
//   into the macro's serial shift / load / write-enable sequence, issues
//   reads and captures data_out on data_valid, and returns one response
//   pulse per accepted request.
// Optional feature: SRAM_SEQ_TIMEOUT_EN -- when defined, a read that sees
//   no data_valid for TIMEOUT r_en cycles is answered with rsp_err = 1 and
//   rsp_data = 0. When undefined, reads wait indefinitely and rsp_err is 0.
// Ports:
//   clk, arst_n        clock (rising edge), synchronous active-low reset
//   req_valid/ready    [1:0] per-requester handshake, ready only in IDLE
//   req_we             [1:0] 1 = write, 0 = read
//   req_addr           [2*AW-1:0] requester i at [i*AW +: AW]
//   req_wdata          [2*COLS-1:0] requester i at [i*COLS +: COLS]
//   rsp_valid/id/data/err  one-cycle response, id = requester index
//   serial_in, shift, load, w_en, r_en, addr   SRAM macro control pins
//   data_valid, data_out                       SRAM macro read return
module sram_seq_ctrl
  import sram_seq_pkg::*;
#(
  parameter  int ROWS    = DEF_ROWS,
  parameter  int COLS    = DEF_COLS,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int AW      = $clog2(ROWS)
) (
  input  logic [0:0]       clk,
  input  logic             arst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_we,
  input  logic [2*AW-1:0]  req_addr,
  input  logic [2*COLS-1:0] req_wdata,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [COLS-1:0]  rsp_data,
  output logic             rsp_err,
  output logic             serial_in,
  output logic             shift,
  output logic             load,
  output logic             w_en,
  output logic             r_en,
  output logic [AW-1:0]    addr,
  input  logic             data_valid,
  input  logic [COLS-1:0]  data_out
);

  localparam int CW = $clog2(COLS) + 1;

  // The write path shifts wdata left by one bit per cycle, so at least two
  // columns are needed; a zero timeout would make a read impossible.
  if (COLS < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("sram_seq_ctrl: COLS must be >= 2 and TIMEOUT >= 1");
  end

  sram_seq_state_e state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] wdata_q, wdata_d;
  logic [COLS-1:0] data_q, data_d;
  logic            id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic arb_en;
  logic gnt_idx;
  logic gnt_vld;
  logic accept;

`ifdef SRAM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
  logic          tmo;

  // tcnt counts completed r_en cycles; this is the last one allowed.
  assign tmo     = (tcnt_q == TW'(TIMEOUT - 1));
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign arb_en = (state_q == ST_IDLE);
  assign accept = arb_en && gnt_vld;

  sram_seq_rr_arb u_arb (
    .clk       (clk[0]),
    .arst_n    (arst_n),
    .valid_i   (req_valid),
    .en_i      (arb_en),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign req_ready = accept ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  // Control pins decode directly from state so every pin not owned by the
  // current state is 0, and reset forces all of them low on the next cycle.
  assign shift     = (state_q == ST_SHIFT);
  assign serial_in = shift && wdata_q[COLS-1];
  assign load      = (state_q == ST_LOAD);
  assign w_en      = (state_q == ST_WRITE);
  assign r_en      = (state_q == ST_READ);
  assign addr      = arb_en ? '0 : addr_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
`ifdef SRAM_SEQ_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d    = gnt_idx;
          addr_d  = gnt_idx ? req_addr[AW +: AW] : req_addr[0 +: AW];
          wdata_d = gnt_idx ? req_wdata[COLS +: COLS] : req_wdata[0 +: COLS];
          data_d  = '0;
          cnt_d   = '0;
`ifdef SRAM_SEQ_TIMEOUT_EN
          tcnt_d  = '0;
          err_d   = 1'b0;
`endif
          state_d = (gnt_idx ? req_we[1] : req_we[0]) ? ST_SHIFT : ST_READ;
        end
      end
      ST_SHIFT: begin
        // MSB goes out first: the bit on serial_in is always wdata_q's top.
        wdata_d = {wdata_q[COLS-2:0], 1'b0};
        if (cnt_q == CW'(COLS - 1)) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LOAD:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_READ: begin
        if (data_valid) begin
          data_d  = data_out;
          state_d = ST_RESP;
        end
`ifdef SRAM_SEQ_TIMEOUT_EN
        else if (tmo) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk[0]) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SRAM_SEQ_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
`ifdef SRAM_SEQ_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// tb_sram_seq_ctrl
//   Bench for sram_seq_ctrl at default geometry. A stub of the SRAM macro
//   reassembles serial writes into its own memory and answers reads after a
//   programmable number of r_en cycles. A reference memory and a model of
//   the round-robin rule predict grants, spacing and responses; responses
//   are queued on acceptance and popped by an independent monitor.
//   Define SRAM_SEQ_TIMEOUT_EN to include the read-timeout scenario.
module tb_sram_seq_ctrl;
  import sram_seq_pkg::*;

  localparam int ROWS    = DEF_ROWS;
  localparam int COLS    = DEF_COLS;
  localparam int TIMEOUT = DEF_TIMEOUT;
  localparam int AW      = DEF_AW;

  typedef struct {
    logic            id;
    logic [COLS-1:0] data;
    logic            err;
  } rsp_t;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [1:0]        req_we = '0;
  logic [2*AW-1:0]   req_addr = '0;
  logic [2*COLS-1:0] req_wdata = '0;
  logic              rsp_valid, rsp_id, rsp_err;
  logic [COLS-1:0]   rsp_data;
  logic              serial_in, shift, load, w_en, r_en;
  logic [AW-1:0]     addr;
  logic              data_valid = 1'b0;
  logic [COLS-1:0]   data_out = '0;

  int tests = 0;
  int fails = 0;
  int violations = 0;
  int cycleCnt = 0;
  int rdDelay = 1;
  bit stall = 1'b0;
  int rdCnt = 0;
  int rEnCycles = 0;
  bit rrPtr = 1'b0;

  logic [COLS-1:0] refMem [ROWS] = '{default: '0};
  logic [COLS-1:0] stubMem [ROWS] = '{default: '0};
  logic [COLS-1:0] sreg, latchReg;

  rsp_t          expQ [$];
  rsp_t          monExp;
  sram_seq_req_t reqQ0 [$];
  sram_seq_req_t reqQ1 [$];

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  sram_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .serial_in  (serial_in),
    .shift      (shift),
    .load       (load),
    .w_en       (w_en),
    .r_en       (r_en),
    .addr       (addr),
    .data_valid (data_valid),
    .data_out   (data_out)
  );

  // SRAM macro stub: serial shift register, load latch, write on w_en.
  always @(posedge clk) begin
    if (shift) sreg <= {sreg[COLS-2:0], serial_in};
    if (load)  latchReg <= sreg;
    if (w_en)  stubMem[addr] <= latchReg;
  end

  // Read side of the stub: data_valid rises in the rdDelay-th r_en cycle,
  // data_out carries noise whenever it is not valid.
  always @(negedge clk) begin
    if (arst_n && r_en) begin
      rdCnt++;
      rEnCycles++;
      if (!stall && rdCnt >= rdDelay) begin
        data_valid = 1'b1;
        data_out   = stubMem[addr];
      end else begin
        data_valid = 1'b0;
        data_out   = COLS'($urandom);
      end
    end else begin
      rdCnt      = 0;
      data_valid = 1'b0;
      data_out   = COLS'($urandom);
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Response monitor and per-cycle invariants.
  always @(negedge clk) begin
    if (arst_n) begin
      if (req_ready == 2'b11 || $countones({shift, load, w_en, r_en}) > 1) violations++;
      if (rsp_valid) begin
        if (expQ.size() == 0) begin
          check("unexpected rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          monExp = expQ.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(monExp.id));
          check("rsp_data", 32'(rsp_data), 32'(monExp.data));
          check("rsp_err", 32'(rsp_err), 32'(monExp.err));
        end
      end
    end
  end

  function automatic sram_seq_req_t mkReq(input bit we, input int a, input int d);
    sram_seq_req_t r;
    r.we    = we;
    r.addr  = AW'(a);
    r.wdata = COLS'(d);
    return r;
  endfunction

  task automatic driveReqs();
    req_valid[0] = (reqQ0.size() > 0);
    req_valid[1] = (reqQ1.size() > 0);
    if (reqQ0.size() > 0) begin
      req_we[0] = reqQ0[0].we; req_addr[0 +: AW] = reqQ0[0].addr; req_wdata[0 +: COLS] = reqQ0[0].wdata;
    end
    if (reqQ1.size() > 0) begin
      req_we[1] = reqQ1[0].we; req_addr[AW +: AW] = reqQ1[0].addr; req_wdata[COLS +: COLS] = reqQ1[0].wdata;
    end
  endtask

  // Presents the heads of both request queues and keeps each requester
  // valid until its queue is empty. Returns just after the last acceptance.
  task automatic applyStimulus();
    bit            first = 1'b1;
    bit            w;
    int            lastAccept = 0;
    int            lastDur = 0;
    int            waitCycles;
    sram_seq_req_t rq;
    rsp_t          e;
    while (reqQ0.size() > 0 || reqQ1.size() > 0) begin
      driveReqs();
      #1;
      w = req_valid[rrPtr] ? rrPtr : !rrPtr;
      waitCycles = 0;
      while (req_ready == 2'b00 && waitCycles < 100) begin
        @(negedge clk);
        waitCycles++;
      end
      if (req_ready == 2'b00) begin
        check("req_ready wait expired", 32'd0, 32'd1);
        reqQ0.delete();
        reqQ1.delete();
        break;
      end
      check("grant", 32'(req_ready), w ? 32'd2 : 32'd1);
      if (!first) check("accept spacing", 32'(cycleCnt - lastAccept), 32'(lastDur));
      first = 1'b0;
      lastAccept = cycleCnt;
      rq = w ? reqQ1[0] : reqQ0[0];
      e.id = w;
      if (rq.we) begin
        e.data = '0; e.err = 1'b0;
        refMem[rq.addr] = rq.wdata;
        lastDur = COLS + 4;
      end else if (stall) begin
        e.data = '0; e.err = 1'b1;
        lastDur = TIMEOUT + 2;
      end else begin
        e.data = refMem[rq.addr]; e.err = 1'b0;
        lastDur = rdDelay + 2;
      end
      expQ.push_back(e);
      rrPtr = !w;
      @(posedge clk);
      #1;
      if (w) void'(reqQ1.pop_front()); else void'(reqQ0.pop_front());
      driveReqs();
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("responses drained", 32'(expQ.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int shiftCnt, firstShift, loadCyc, wenCyc, rspCyc, busyReady, rEnStart;
    logic [COLS-1:0] bits;
    logic [AW-1:0]   wenAddr;
    logic [COLS-1:0] old7;

    // Reset state.
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({req_ready, serial_in, shift, load, w_en, r_en, addr,
                                rsp_valid, rsp_id, rsp_data, rsp_err}), 32'd0);
    arst_n = 1'b1;
    @(negedge clk);

    // Write 8'hA5 to addr 3 from requester 0, cycle-exact pin checks.
    reqQ0.push_back(mkReq(1'b1, 3, 8'hA5));
    applyStimulus();
    shiftCnt = 0; firstShift = -1; loadCyc = -1; wenCyc = -1; rspCyc = -1;
    bits = '0; wenAddr = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (shift) begin
        if (firstShift < 0) firstShift = c;
        shiftCnt++;
        bits = {bits[COLS-2:0], serial_in};
      end
      if (load) loadCyc = c;
      if (w_en) begin wenCyc = c; wenAddr = addr; end
      if (rsp_valid) rspCyc = c;
    end
    check("serial bits", 32'(bits), 32'hA5);
    check("shift count", 32'(shiftCnt), 32'd8);
    check("first shift cycle", 32'(firstShift), 32'd1);
    check("load cycle", 32'(loadCyc), 32'd9);
    check("w_en cycle", 32'(wenCyc), 32'd10);
    check("w_en addr", 32'(wenAddr), 32'd3);
    check("write rsp cycle", 32'(rspCyc), 32'd11);
    waitDrain();

    // Requester 1 reads addr 3 with a 4-cycle data_valid delay.
    rdDelay = 4;
    reqQ1.push_back(mkReq(1'b0, 3, 0));
    applyStimulus();
    waitDrain();

    // Both requesters continuously valid for 4 transactions: 0,1,0,1.
    rdDelay = 1;
    reqQ0.push_back(mkReq(1'b1, 6, 8'h3C));
    reqQ0.push_back(mkReq(1'b0, 6, 0));
    reqQ1.push_back(mkReq(1'b0, 3, 0));
    reqQ1.push_back(mkReq(1'b1, 12, 8'hC3));
    applyStimulus();
    waitDrain();

    // A requester may drop valid before acceptance; nothing is latched.
    reqQ0.push_back(mkReq(1'b1, 9, 8'h99));
    applyStimulus();
    busyReady = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[AW +: AW] = AW'($urandom);
      #1;
      if (req_ready != 2'b00) busyReady++;
    end
    req_valid[1] = 1'b0;
    check("ready while busy", 32'(busyReady), 32'd0);
    waitDrain();

`ifdef SRAM_SEQ_TIMEOUT_EN
    // Read that never sees data_valid, then a normal write.
    stall = 1'b1;
    rEnStart = rEnCycles;
    reqQ1.push_back(mkReq(1'b0, 5, 0));
    applyStimulus();
    waitDrain();
    check("r_en cycles before timeout", 32'(rEnCycles - rEnStart), 32'(TIMEOUT));
    stall = 1'b0;
    reqQ0.push_back(mkReq(1'b1, 5, 8'h5E));
    reqQ1.push_back(mkReq(1'b0, 5, 0));
    applyStimulus();
    waitDrain();
`else
    rEnStart = rEnCycles;
`endif

    // Reset during shift cycle 4 of a write: pins drop, no response.
    old7 = refMem[7];
    reqQ0.push_back(mkReq(1'b1, 7, 8'hE7));
    applyStimulus();
    repeat (4) @(negedge clk);
    arst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pins after mid-write reset", 32'({req_ready, serial_in, shift, load, w_en, r_en, addr,
                                             rsp_valid, rsp_id, rsp_data, rsp_err}), 32'd0);
    expQ.delete();
    refMem[7] = old7;
    rrPtr = 1'b0;
    arst_n = 1'b1;
    repeat (14) @(negedge clk);
    reqQ0.push_back(mkReq(1'b1, ROWS - 1, 8'h5A));
    reqQ1.push_back(mkReq(1'b0, 7, 0));
    reqQ1.push_back(mkReq(1'b0, ROWS - 1, 0));
    applyStimulus();
    waitDrain();

    // Randomized mix of reads and writes from both requesters.
    for (int it = 0; it < 20; it++) begin
      int n0, n1;
      rdDelay = $urandom_range(1, 5);
      n0 = $urandom_range(0, 2);
      n1 = (n0 == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
      for (int k = 0; k < n0; k++)
        reqQ0.push_back(mkReq(1'($urandom_range(0, 1)), $urandom_range(0, ROWS - 1), $urandom));
      for (int k = 0; k < n1; k++)
        reqQ1.push_back(mkReq(1'($urandom_range(0, 1)), $urandom_range(0, ROWS - 1), $urandom));
      applyStimulus();
      waitDrain();
    end

    // Full sweep: requester 0 writes addr*17, requester 1 reads back.
    rdDelay = 2;
    for (int a = 0; a < ROWS; a++) begin
      reqQ0.push_back(mkReq(1'b1, a, a * 17));
      reqQ1.push_back(mkReq(1'b0, a, 0));
    end
    applyStimulus();
    waitDrain();

    check("per-cycle invariant violations", 32'(violations), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
